// File: rtl/button_bank_if.sv
// Push-button bank signal bundle: raw button levels and repeat enables in,
// debounced levels and press/repeat strobes out.
interface button_bank_if #(
  parameter int N_CH = 5
);
  logic [N_CH-1:0] PB;
  logic [N_CH-1:0] REPEAT_EN;
  logic [N_CH-1:0] DPB;
  logic [N_CH-1:0] SCEN;
  logic [N_CH-1:0] CCEN;
  logic            ANY_SCEN;

  modport master (
    output PB, REPEAT_EN,
    input  DPB, SCEN, CCEN, ANY_SCEN
  );

  modport slave (
    input  PB, REPEAT_EN,
    output DPB, SCEN, CCEN, ANY_SCEN
  );
endinterface

// File: rtl/button_bank.sv
// Bank of independent push-button debouncers with single-press strobe and
// optional auto-repeat strobes while a button is held.
module button_bank #(
  parameter int N_CH    = 5,
  parameter int N_DC    = 15,
  parameter int RPT_DLY = 50_000_000,
  parameter int RPT_PER = 10_000_000
) (
  input  logic          Clk,
  input  logic          Reset,
  button_bank_if.slave  bb
);

  localparam int RC_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int RC_W   = (RC_MAX > 1) ? $clog2(RC_MAX) : 1;

  localparam logic [N_DC-1:0] DC_MAX = '1;
  localparam logic [RC_W-1:0] DLY_M1 = RC_W'(RPT_DLY - 1);
  localparam logic [RC_W-1:0] PER_M1 = RC_W'(RPT_PER - 1);

  typedef enum logic [1:0] {
    IDLE,
    CHK_PRESS,
    HELD,
    CHK_RELEASE
  } state_e;

  logic [N_CH-1:0] pb_meta_q, pb_s_q;
  logic [N_CH-1:0] dpb_q, scen_q, ccen_q;
  logic            any_scen_q;
  logic [N_CH-1:0] dpb_d, scen_d, ccen_d;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_e          state_q, state_d;
    logic [N_DC-1:0] dc_q, dc_d;
    logic [RC_W-1:0] rc_q, rc_d;
    logic            first_q, first_d;
    logic            scen_c, ccen_c;

    always_ff @(posedge Clk) begin
      if (Reset) begin
        state_q <= IDLE;
        dc_q    <= '0;
        rc_q    <= '0;
        first_q <= 1'b0;
      end else begin
        state_q <= state_d;
        dc_q    <= dc_d;
        rc_q    <= rc_d;
        first_q <= first_d;
      end
    end

    always_comb begin
      state_d = state_q;
      dc_d    = dc_q;
      rc_d    = rc_q;
      first_d = first_q;
      scen_c  = 1'b0;
      ccen_c  = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pb_s_q[g]) begin
            state_d = CHK_PRESS;
            dc_d    = '0;
          end
        end
        CHK_PRESS: begin
          if (!pb_s_q[g]) begin
            state_d = IDLE;
          end else if (dc_q == DC_MAX) begin
            state_d = HELD;
            scen_c  = 1'b1;
            rc_d    = '0;
            first_d = 1'b0;
          end else begin
            dc_d = dc_q + 1'b1;
          end
        end
        HELD: begin
          if (!pb_s_q[g]) begin
            state_d = CHK_RELEASE;
            dc_d    = '0;
          end else begin
            // rc keeps counting with repeat disabled so a later enable keeps phase
            rc_d = rc_q + 1'b1;
            if (bb.REPEAT_EN[g]) begin
              if (!first_q && rc_q == DLY_M1) begin
                ccen_c  = 1'b1;
                rc_d    = '0;
                first_d = 1'b1;
              end else if (first_q && rc_q == PER_M1) begin
                ccen_c = 1'b1;
                rc_d   = '0;
              end
            end
          end
        end
        CHK_RELEASE: begin
          if (pb_s_q[g]) begin
            state_d = HELD;
          end else if (dc_q == DC_MAX) begin
            state_d = IDLE;
          end else begin
            dc_d = dc_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    assign dpb_d[g]  = (state_d == HELD) || (state_d == CHK_RELEASE);
    assign scen_d[g] = scen_c;
    assign ccen_d[g] = ccen_c;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pb_meta_q  <= '0;
      pb_s_q     <= '0;
      dpb_q      <= '0;
      scen_q     <= '0;
      ccen_q     <= '0;
      any_scen_q <= 1'b0;
    end else begin
      pb_meta_q  <= bb.PB;
      pb_s_q     <= pb_meta_q;
      dpb_q      <= dpb_d;
      scen_q     <= scen_d;
      ccen_q     <= ccen_d;
      any_scen_q <= |scen_d;
    end
  end

  assign bb.DPB      = dpb_q;
  assign bb.SCEN     = scen_q;
  assign bb.CCEN     = ccen_q;
  assign bb.ANY_SCEN = any_scen_q;

endmodule

// File: tb/tb_button_bank.sv
// Bench for button_bank: directed button sequences schedule expected strobe
// and level events into a queue; a per-cycle checker pops and compares them.
module tb_button_bank;

  localparam int NC = 2;
  localparam int K_SCEN = 0;
  localparam int K_CCEN = 1;
  localparam int K_DPB  = 2;

  typedef struct {
    int   cyc;
    int   kind;
    int   ch;
    logic val;
  } ev_t;

  logic Clk = 1'b0;
  logic Reset;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  ev_t  sb[$];

  logic [NC-1:0] exp_scen, exp_ccen;
  logic [NC-1:0] exp_dpb = '0;
  int c, t, g, r, n;

  button_bank_if #(.N_CH(NC)) bb_if ();

  button_bank #(
    .N_CH(NC), .N_DC(2), .RPT_DLY(4), .RPT_PER(2)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bb   (bb_if)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic void push(input int kind, input int ch, input int at, input logic val);
    ev_t e;
    e.cyc  = at;
    e.kind = kind;
    e.ch   = ch;
    e.val  = val;
    sb.push_back(e);
  endfunction

  task automatic step(input int k);
    repeat (k) @(negedge Clk);
  endtask

  // Per-cycle checker: anything not scheduled for this cycle must be quiet.
  initial begin
    forever begin
      @(negedge Clk);
      exp_scen = '0;
      exp_ccen = '0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          case (sb[i].kind)
            K_SCEN:  exp_scen[sb[i].ch] = 1'b1;
            K_CCEN:  exp_ccen[sb[i].ch] = 1'b1;
            default: exp_dpb[sb[i].ch]  = sb[i].val;
          endcase
          sb.delete(i);
        end
      end
      vectors++;
      assert (bb_if.SCEN === exp_scen) else begin
        miscompares++;
        $error("FAIL scen cyc=%0d got=%b exp=%b", cyc, bb_if.SCEN, exp_scen);
      end
      vectors++;
      assert (bb_if.CCEN === exp_ccen) else begin
        miscompares++;
        $error("FAIL ccen cyc=%0d got=%b exp=%b", cyc, bb_if.CCEN, exp_ccen);
      end
      vectors++;
      assert (bb_if.DPB === exp_dpb) else begin
        miscompares++;
        $error("FAIL dpb cyc=%0d got=%b exp=%b", cyc, bb_if.DPB, exp_dpb);
      end
      vectors++;
      assert (bb_if.ANY_SCEN === (|exp_scen)) else begin
        miscompares++;
        $error("FAIL any_scen cyc=%0d got=%b exp=%b", cyc, bb_if.ANY_SCEN, |exp_scen);
      end
    end
  end

  initial begin
    Reset = 1'b1;
    bb_if.PB = '0;
    bb_if.REPEAT_EN = '0;
    step(3);
    Reset = 1'b0;
    step(2);

    // Clean press on channel 0, no repeat
    c = cyc;
    bb_if.PB = 2'b01;
    push(K_SCEN, 0, c + 7, 1'b1);
    push(K_DPB, 0, c + 7, 1'b1);
    step(20);
    c = cyc;
    bb_if.PB = 2'b00;
    push(K_DPB, 0, c + 7, 1'b0);
    step(12);

    // Bounce: 2-cycle toggles, then held high
    c = cyc;
    for (int i = 0; i < 12; i++) begin
      bb_if.PB[0] = ((i % 4) < 2) ? 1'b1 : 1'b0;
      step(1);
    end
    bb_if.PB[0] = 1'b1;
    push(K_SCEN, 0, c + 19, 1'b1);
    push(K_DPB, 0, c + 19, 1'b1);
    step(10);
    c = cyc;
    bb_if.PB = 2'b00;
    push(K_DPB, 0, c + 7, 1'b0);
    step(12);

    // Auto-repeat: first repeat 4 after SCEN, then every 2
    bb_if.REPEAT_EN = 2'b01;
    c = cyc;
    t = c + 7;
    r = c + 25;
    bb_if.PB = 2'b01;
    push(K_SCEN, 0, t, 1'b1);
    push(K_DPB, 0, t, 1'b1);
    for (int e = t + 4; e <= r + 2; e += 2) push(K_CCEN, 0, e, 1'b1);
    push(K_DPB, 0, r + 7, 1'b0);
    step(r - c);
    bb_if.PB = 2'b00;
    step(12);

    // Release glitch of 2 cycles while held; repeat phase freezes meanwhile
    c = cyc;
    t = c + 7;
    g = t + 5;
    r = c + 40;
    bb_if.PB = 2'b01;
    push(K_SCEN, 0, t, 1'b1);
    push(K_DPB, 0, t, 1'b1);
    n = 0;
    for (int e = t + 1; e <= r + 2; e++) begin
      if (e <= g + 2 || e >= g + 6) begin
        n++;
        if (n == 4 || (n > 4 && (n - 4) % 2 == 0)) push(K_CCEN, 0, e, 1'b1);
      end
    end
    push(K_DPB, 0, r + 7, 1'b0);
    step(g - c);
    bb_if.PB = 2'b00;
    step(2);
    bb_if.PB = 2'b01;
    step(r - g - 2);
    bb_if.PB = 2'b00;
    step(12);
    bb_if.REPEAT_EN = 2'b00;

    // Simultaneous press on both channels
    c = cyc;
    bb_if.PB = 2'b11;
    for (int ch = 0; ch < NC; ch++) begin
      push(K_SCEN, ch, c + 7, 1'b1);
      push(K_DPB, ch, c + 7, 1'b1);
    end
    step(10);
    c = cyc;
    bb_if.PB = 2'b00;
    for (int ch = 0; ch < NC; ch++) push(K_DPB, ch, c + 7, 1'b0);
    step(12);

    // Reset pulse while held forces a full new debounce
    c = cyc;
    bb_if.PB = 2'b01;
    push(K_SCEN, 0, c + 7, 1'b1);
    push(K_DPB, 0, c + 7, 1'b1);
    step(12);
    Reset = 1'b1;
    push(K_DPB, 0, c + 13, 1'b0);
    step(1);
    Reset = 1'b0;
    push(K_SCEN, 0, c + 20, 1'b1);
    push(K_DPB, 0, c + 20, 1'b1);
    step(12);
    c = cyc;
    bb_if.PB = 2'b00;
    push(K_DPB, 0, c + 7, 1'b0);
    step(12);

    vectors++;
    assert (sb.size() === 0) else begin
      miscompares++;
      $error("FAIL pending_events got=%0d exp=0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
